// File: rtl/byte_uart_pkg.sv
// Shared types and constants for the byte-output UART transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package byte_uart_pkg;

    localparam int DATA_BITS = 8;

    // PARITY is only entered when the parity build is selected.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Clock cycles per serial bit, truncated.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers; dout is registered on pop.
// Latency: a pushed byte is poppable the cycle after the push; dout valid the cycle after the pop.
// Backpressure: push while full and pop while empty are ignored; the caller owns the full/empty policy.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Same index with differing wrap bits means every slot is occupied.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Storage array is not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer advance and registered read port.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                dout   <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/byte_uart_tx.sv
// Buffers strobed SoC output bytes and serialises them as 8N1 UART (8E1 when BYTE_UART_TX_PARITY_EN is defined).
// Latency: strobe at edge N with idle FSM -> pop at N+1 -> uart_tx falls after N+2; frame is 10 (11) bit times.
// Backpressure: none toward the producer; bytes arriving while the FIFO is full are dropped and set sticky overflow.
module byte_uart_tx #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] out_byte,
    input  logic       out_byte_en,
    output logic       uart_tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    import byte_uart_pkg::*;

    localparam int              CPB       = clks_per_bit(CLK_HZ, BAUD);
    localparam int              BW        = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CPB - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;

    uart_state_t   state;
    logic [7:0]    sh;
    logic [2:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic          bit_end;
`ifdef BYTE_UART_TX_PARITY_EN
    logic          par;
`endif

    // Full is the pre-edge occupancy, so a push coinciding with a pop while full is still dropped.
    assign fifo_push = out_byte_en && !fifo_full;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    // Pop from IDLE, or in the last stop cycle so back-to-back frames have no idle gap.
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign busy      = (state != IDLE) || !fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (out_byte),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (out_byte_en && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Frame sequencer. The popped byte lands in the FIFO's dout register one cycle after the pop,
    // so it is captured into sh at the end of the start bit, where it is guaranteed stable.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            sh       <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
`ifdef BYTE_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!fifo_empty) begin
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        sh       <= fifo_dout;
`ifdef BYTE_UART_TX_PARITY_EN
                        par      <= ^fifo_dout;
`endif
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        sh       <= {1'b0, sh[7:1]};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef BYTE_UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef BYTE_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= fifo_empty ? IDLE : START;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered line driver, one cycle behind the state it reflects; idles high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_tx <= 1'b1;
        end else begin
            case (state)
                START:   uart_tx <= 1'b0;
                DATA:    uart_tx <= sh[0];
`ifdef BYTE_UART_TX_PARITY_EN
                PARITY:  uart_tx <= par;
`endif
                default: uart_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_uart_tx.sv
// Directed bench for byte_uart_tx with a serial-line decoder feeding a byte scoreboard.
// Latency: checks strobe-to-start-bit timing, frame length and busy release.
// Backpressure: exercises FIFO overflow, same-cycle push/pop at full, and reset mid-frame.
module tb_byte_uart_tx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 16;
    localparam int CPB    = 10;
`ifdef BYTE_UART_TX_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    localparam int F      = NBITS * CPB;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] out_byte = 8'h00;
    logic       out_byte_en = 1'b0;
    logic       uart_tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int frames = 0;
    int cyc = 0;
    int f0;
    int n;
    logic [7:0] exp_q[$];
    int start_times[$];

    byte_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .out_byte    (out_byte),
        .out_byte_en (out_byte_en),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line decoder: samples mid-bit on falling clock edges, aborts on reset.
    int         mon_cnt = 0;
    int         mon_b = 0;
    bit         mon_act = 1'b0;
    logic [7:0] mon_dat = 8'h00;
    logic [7:0] mon_exp = 8'h00;
    logic       mon_par = 1'b0;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (uart_tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
                start_times.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) begin
                mon_b = mon_cnt / CPB;
                if (mon_b == 0) check("start_bit", 32'(uart_tx), 32'd0);
                if (mon_b >= 1 && mon_b <= 8) mon_dat[mon_b-1] = uart_tx;
                if (mon_b == 9) mon_par = uart_tx;
                if (mon_b == NBITS - 1) begin
                    check("stop_bit", 32'(uart_tx), 32'd1);
                    frames++;
                    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_exp = exp_q.pop_front();
                        check("rx_byte", 32'(mon_dat), 32'(mon_exp));
`ifdef BYTE_UART_TX_PARITY_EN
                        check("parity_bit", 32'(mon_par), 32'(^mon_exp));
`endif
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    // Drive one single-cycle strobe; returns at the falling edge after the sampling edge.
    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        out_byte_en = 1'b1;
        out_byte    = b;
        @(negedge clk);
        out_byte_en = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (busy !== 1'b0 && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single byte: start bit appears two edges after the strobe edge
        exp_q.push_back(8'h55);
        strobe(8'h55);
        check("t1_busy_after_strobe", 32'(busy), 32'd1);
        check("t1_tx_at_n", 32'(uart_tx), 32'd1);
        @(negedge clk);
        check("t1_tx_at_n1", 32'(uart_tx), 32'd1);
        @(negedge clk);
        check("t1_tx_at_n2", 32'(uart_tx), 32'd0);
        repeat (F - 2) @(negedge clk);
        check("t1_busy_last_stop", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_busy_released", 32'(busy), 32'd0);
        check("t1_frames", 32'(frames), 32'd1);

        // Back-to-back "A\n"
        f0 = frames;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h0A);
        @(negedge clk);
        out_byte_en = 1'b1;
        out_byte    = 8'h41;
        @(negedge clk);
        out_byte    = 8'h0A;
        @(negedge clk);
        out_byte_en = 1'b0;
        wait_idle(3 * F);
        check("t2_frames", 32'(frames - f0), 32'd2);
        n = start_times.size();
        check("t2_two_starts", 32'(n >= 2), 32'd1);
        if (n >= 2) check("t2_no_gap", 32'(start_times[n-1] - start_times[n-2]), 32'(F));

        // Overflow: 20 strobes, 1 popped early + 16 buffered, 3 dropped
        f0 = frames;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("t3_overflow", 32'(overflow), 32'(i - 1 >= 17));
                check("t3_full", 32'(fifo_full), 32'(i - 1 >= 16));
            end
            out_byte_en = 1'b1;
            out_byte    = 8'(8'h10 + i);
            if (i < 17) exp_q.push_back(8'(8'h10 + i));
        end
        @(negedge clk);
        out_byte_en = 1'b0;
        check("t3_overflow_last", 32'(overflow), 32'd1);
        check("t3_full_last", 32'(fifo_full), 32'd1);
        wait_idle(20 * F);
        check("t3_frames", 32'(frames - f0), 32'd17);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 3 of 0xA5, with a second byte still buffered
        exp_q.push_back(8'hA5);
        strobe(8'hA5);
        strobe(8'h99);
        repeat (43) @(negedge clk);
        check("t4_mid_bit3", 32'(uart_tx), 32'd0);
        resetn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t4_rst_tx", 32'(uart_tx), 32'd1);
        check("t4_rst_busy", 32'(busy), 32'd0);
        check("t4_rst_overflow", 32'(overflow), 32'd0);
        check("t4_rst_full", 32'(fifo_full), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        f0 = frames;
        exp_q.push_back(8'h3C);
        strobe(8'h3C);
        wait_idle(3 * F);
        check("t4_frames", 32'(frames - f0), 32'd1);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Full boundary: push coincides with the stop-bit pop while full
        f0 = frames;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            out_byte_en = 1'b1;
            out_byte    = 8'(8'hC0 + i);
            exp_q.push_back(8'(8'hC0 + i));
        end
        @(negedge clk);
        out_byte_en = 1'b0;
        repeat (F - 16) @(negedge clk);
        check("t5_full_before", 32'(fifo_full), 32'd1);
        check("t5_ovf_before", 32'(overflow), 32'd0);
        out_byte_en = 1'b1;
        out_byte    = 8'hEE;
        @(negedge clk);
        out_byte_en = 1'b0;
        check("t5_ovf_after", 32'(overflow), 32'd1);
        check("t5_full_after", 32'(fifo_full), 32'd0);
        wait_idle(20 * F);
        check("t5_frames", 32'(frames - f0), 32'd17);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef BYTE_UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0 (checked by the decoder)
        f0 = frames;
        exp_q.push_back(8'h07);
        strobe(8'h07);
        wait_idle(3 * F);
        exp_q.push_back(8'h03);
        strobe(8'h03);
        wait_idle(3 * F);
        check("t6_frames", 32'(frames - f0), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
